// File: rtl/mmuart_bridge_pkg.sv
// Shared definitions for the mmuart host bridge.
// Holds the TX state encoding, the byte width and the level-width helper.
package mmuart_bridge_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } tx_state_t;

   // Width needed to count 0..depth inclusive for a power-of-two depth.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mmuart_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO used for both bridge directions.
// Pointers carry one extra MSB so full and empty are told apart by the
// toggled wrap bit; level is the plain pointer difference.
module mmuart_bridge_fifo
   import mmuart_bridge_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = BYTE_W,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = level_w(DEPTH)
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [LW-1:0]    wr_ptr;
   logic [LW-1:0]    rd_ptr;

   // Pointer advance; the caller only pops when non-empty and only pushes
   // into a full FIFO when the head is popped in the same cycle.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LW'(1);
         if (pop)  rd_ptr <= rd_ptr + LW'(1);
      end
   end

   // Storage write; data array carries no reset.
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign level = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mmuart_host_bridge.sv
// Host-side buffered front end for the mmuart byte core.
// TX: host stream -> TX FIFO -> one tx_wr strobe per frame, next byte only
// after tx_done. RX: every rx_done byte -> RX FIFO -> host stream, with a
// sticky overrun flag when a byte arrives into a full FIFO.
// Optional: define MMUART_BRIDGE_IRQ_EN to build the interrupt logic;
// otherwise irq is tied low.
module mmuart_host_bridge
   import mmuart_bridge_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int LW = level_w(DEPTH)
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [BYTE_W-1:0] tx_in_data,
   input  logic              tx_in_valid,
   output logic              tx_in_ready,
   output logic [BYTE_W-1:0] uart_tx_data,
   output logic              uart_tx_wr,
   input  logic              uart_tx_done,
   input  logic [BYTE_W-1:0] uart_rx_data,
   input  logic              uart_rx_done,
   output logic [BYTE_W-1:0] rx_out_data,
   output logic              rx_out_valid,
   input  logic              rx_out_ready,
   output logic [LW-1:0]     tx_level,
   output logic [LW-1:0]     rx_level,
   output logic              rx_overrun,
   input  logic              overrun_clr,
   output logic              irq
);

   tx_state_t         tx_state;
   logic              tx_push;
   logic              tx_pop;
   logic              tx_full;
   logic              tx_empty;
   logic [BYTE_W-1:0] tx_head;

   logic              rx_push;
   logic              rx_pop;
   logic              rx_full;
   logic              rx_empty;
   logic              rx_drop;

   // A full TX FIFO refuses the host even if a launch frees a slot this cycle.
   assign tx_in_ready = !tx_full;
   assign tx_push     = tx_in_valid && !tx_full;
   assign tx_pop      = (tx_state == IDLE) && !tx_empty;

   mmuart_bridge_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BYTE_W)
   ) u_tx_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (tx_push),
      .pop       (tx_pop),
      .din       (tx_in_data),
      .head      (tx_head),
      .level     (tx_level),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   // TX launcher: one strobe per frame, then hold off until the core reports done.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         tx_state     <= IDLE;
         uart_tx_wr   <= 1'b0;
         uart_tx_data <= '0;
      end else begin
         uart_tx_wr <= 1'b0;
         case (tx_state)
            IDLE: begin
               if (!tx_empty) begin
                  uart_tx_data <= tx_head;
                  uart_tx_wr   <= 1'b1;
                  tx_state     <= WAIT;
               end
            end
            WAIT: begin
               if (uart_tx_done) tx_state <= IDLE;
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   // A full RX FIFO still takes a byte when the host drains the head this cycle.
   assign rx_pop       = !rx_empty && rx_out_ready;
   assign rx_push      = uart_rx_done && (!rx_full || rx_pop);
   assign rx_drop      = uart_rx_done && rx_full && !rx_pop;
   assign rx_out_valid = !rx_empty;

   mmuart_bridge_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BYTE_W)
   ) u_rx_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (rx_push),
      .pop       (rx_pop),
      .din       (uart_rx_data),
      .head      (rx_out_data),
      .level     (rx_level),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // Sticky overrun; a new drop outranks a simultaneous clear.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)       rx_overrun <= 1'b0;
      else if (rx_drop)     rx_overrun <= 1'b1;
      else if (overrun_clr) rx_overrun <= 1'b0;
   end

`ifdef MMUART_BRIDGE_IRQ_EN
   logic tx_empty_event;

   // TX drained while a frame is in flight; the next host byte clears it.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)                              tx_empty_event <= 1'b0;
      else if (tx_push)                            tx_empty_event <= 1'b0;
      else if ((tx_state == WAIT) && tx_empty)     tx_empty_event <= 1'b1;
   end

   // Registered interrupt request from pending RX data, overrun or TX drain.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) irq <= 1'b0;
      else            irq <= (rx_level != '0) | rx_overrun | tx_empty_event;
   end
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmuart_host_bridge.sv
// Bench for mmuart_host_bridge: directed scenarios plus a randomized phase,
// checked by a queue-based reference model and a negedge monitor.
module tb_mmuart_host_bridge;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          sys_clk;
   logic          sys_rst_n;
   logic [7:0]    tx_in_data;
   logic          tx_in_valid;
   logic          tx_in_ready;
   logic [7:0]    uart_tx_data;
   logic          uart_tx_wr;
   logic          uart_tx_done;
   logic [7:0]    uart_rx_data;
   logic          uart_rx_done;
   logic [7:0]    rx_out_data;
   logic          rx_out_valid;
   logic          rx_out_ready;
   logic [LW-1:0] tx_level;
   logic [LW-1:0] rx_level;
   logic          rx_overrun;
   logic          overrun_clr;
   logic          irq;

   mmuart_host_bridge #(.DEPTH(DEPTH)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .tx_in_data   (tx_in_data),
      .tx_in_valid  (tx_in_valid),
      .tx_in_ready  (tx_in_ready),
      .uart_tx_data (uart_tx_data),
      .uart_tx_wr   (uart_tx_wr),
      .uart_tx_done (uart_tx_done),
      .uart_rx_data (uart_rx_data),
      .uart_rx_done (uart_rx_done),
      .rx_out_data  (rx_out_data),
      .rx_out_valid (rx_out_valid),
      .rx_out_ready (rx_out_ready),
      .tx_level     (tx_level),
      .rx_level     (rx_level),
      .rx_overrun   (rx_overrun),
      .overrun_clr  (overrun_clr),
      .irq          (irq)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   // Reference model state: counts of bytes held, frame-in-flight flag,
   // expected strobe and overrun, plus scoreboard queues of expected bytes.
   int         tx_cnt = 0;
   int         rx_cnt = 0;
   bit         m_busy = 1'b0;
   bit         m_wr   = 1'b0;
   bit         m_ovr  = 1'b0;
   logic [7:0] tx_exp[$];
   logic [7:0] rx_exp[$];
   bit         launch, tx_acc, rx_pop, ovr_set;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: applies the bridge's rules to the inputs at each rising edge.
   always @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         tx_cnt = 0; rx_cnt = 0; m_busy = 0; m_wr = 0; m_ovr = 0;
         tx_exp.delete(); rx_exp.delete();
      end else begin
         launch = !m_busy && (tx_cnt != 0);
         tx_acc = tx_in_valid && (tx_cnt != DEPTH);
         m_wr   = launch;
         if (launch)                    m_busy = 1'b1;
         else if (m_busy && uart_tx_done) m_busy = 1'b0;
         tx_cnt = tx_cnt + int'(tx_acc) - int'(launch);
         if (tx_acc) tx_exp.push_back(tx_in_data);

         rx_pop  = (rx_cnt != 0) && rx_out_ready;
         ovr_set = 1'b0;
         if (uart_rx_done) begin
            if ((rx_cnt != DEPTH) || rx_pop) begin
               rx_exp.push_back(uart_rx_data);
               rx_cnt++;
            end else begin
               ovr_set = 1'b1;
            end
         end
         if (rx_pop) rx_cnt--;
         if (ovr_set)          m_ovr = 1'b1;
         else if (overrun_clr) m_ovr = 1'b0;
      end
   end

   // Monitor: compares DUT outputs with the model away from the active edge.
   always @(negedge sys_clk) begin
      if (mon_en) begin
         chk("tx_in_ready", tx_in_ready, tx_cnt != DEPTH);
         chk("tx_level", tx_level, tx_cnt);
         chk("rx_level", rx_level, rx_cnt);
         chk("rx_out_valid", rx_out_valid, rx_cnt != 0);
         chk("uart_tx_wr", uart_tx_wr, m_wr);
         chk("rx_overrun", rx_overrun, m_ovr);
`ifndef MMUART_BRIDGE_IRQ_EN
         chk("irq", irq, 0);
`endif
         if (uart_tx_wr) begin
            if (tx_exp.size() == 0) chk("tx_byte_unexpected", 1, 0);
            else                    chk("tx_byte", uart_tx_data, tx_exp.pop_front());
         end
         if (rx_out_valid && rx_out_ready) begin
            if (rx_exp.size() == 0) chk("rx_byte_unexpected", 1, 0);
            else                    chk("rx_byte", rx_out_data, rx_exp.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drain_tx();
      int k;
      tx_in_valid = 1'b0;
      for (k = 0; k < 600 && (tx_cnt != 0 || m_busy); k++) begin
         uart_tx_done = (k % 3 == 0);
         tick();
      end
      uart_tx_done = 1'b0;
      tick();
      if (tx_cnt != 0 || m_busy) chk("drain_tx_timeout", 1, 0);
   endtask

   task automatic drain_rx();
      int k;
      uart_rx_done = 1'b0;
      rx_out_ready = 1'b1;
      for (k = 0; k < 60 && rx_cnt != 0; k++) tick();
      rx_out_ready = 1'b0;
      tick();
      if (rx_cnt != 0) chk("drain_rx_timeout", 1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst_n = 1'b0; tx_in_data = '0; tx_in_valid = 1'b0; uart_tx_done = 1'b0;
      uart_rx_data = '0; uart_rx_done = 1'b0; rx_out_ready = 1'b0; overrun_clr = 1'b0;
      tick();
      mon_en = 1'b1;
      tick(); tick();
      sys_rst_n = 1'b1;
      chk("rst_tx_data", uart_tx_data, 0);
      chk("rst_tx_ready", tx_in_ready, 1);
      chk("rst_rx_valid", rx_out_valid, 0);
      chk("rst_levels", {tx_level, rx_level}, 0);

      // Single byte: strobe appears in the 2nd cycle after acceptance.
      tx_in_data = 8'h55; tx_in_valid = 1'b1;
      tick();
      tx_in_valid = 1'b0;
      chk("t1_wr_early", uart_tx_wr, 0);
      tick();
      chk("t1_wr", uart_tx_wr, 1);
      chk("t1_data", uart_tx_data, 8'h55);
      tick();
      chk("t1_wr_pulse", uart_tx_wr, 0);
      repeat (8) tick();
      uart_tx_done = 1'b1; tick(); uart_tx_done = 1'b0; tick();
      chk("t1_level", tx_level, 0);

      // Seventeen bytes into a stalled core: first launches, 16 fill the FIFO.
      for (int i = 0; i <= 16; i++) begin
         tx_in_data = 8'(i); tx_in_valid = 1'b1;
         tick();
      end
      tx_in_valid = 1'b0;
      chk("t2_full_level", tx_level, 16);
      chk("t2_not_ready", tx_in_ready, 0);
      tx_in_data = 8'h11; tx_in_valid = 1'b1;
      tick();
      tx_in_valid = 1'b0;
      chk("t2_reject", tx_level, 16);
      repeat (6) tick();
      drain_tx();

      // RX ordering.
      rx_out_ready = 1'b0;
      uart_rx_done = 1'b1;
      uart_rx_data = 8'hA1; tick();
      uart_rx_data = 8'hB2; tick();
      uart_rx_data = 8'hC3; tick();
      uart_rx_done = 1'b0;
      chk("t3_level", rx_level, 3);
      chk("t3_head", rx_out_data, 8'hA1);
      rx_out_ready = 1'b1;
      repeat (3) tick();
      rx_out_ready = 1'b0;
      chk("t3_empty", rx_out_valid, 0);

      // RX overrun behaviour at full.
      uart_rx_done = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         uart_rx_data = 8'($urandom); tick();
      end
      uart_rx_data = 8'hEE; tick();
      uart_rx_done = 1'b0;
      chk("t4_ovr", rx_overrun, 1);
      chk("t4_level", rx_level, 16);
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      chk("t4_clr", rx_overrun, 0);
      uart_rx_done = 1'b1; rx_out_ready = 1'b1; uart_rx_data = 8'hEE; tick();
      uart_rx_done = 1'b0; rx_out_ready = 1'b0;
      chk("t4_pop_push_ovr", rx_overrun, 0);
      chk("t4_pop_push_level", rx_level, 16);
      uart_rx_done = 1'b1; overrun_clr = 1'b1; uart_rx_data = 8'h77; tick();
      uart_rx_done = 1'b0; overrun_clr = 1'b0;
      chk("t4_set_wins", rx_overrun, 1);
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      drain_rx();

      // Reset in the middle of a frame with bytes queued.
      for (int i = 0; i < 6; i++) begin
         tx_in_data = 8'h30 + 8'(i); tx_in_valid = 1'b1; tick();
      end
      tx_in_valid = 1'b0;
      tick();
      chk("t5_queued", tx_level, 5);
      sys_rst_n = 1'b0; tick(); sys_rst_n = 1'b1;
      chk("t5_tx_level", tx_level, 0);
      chk("t5_rx_level", rx_level, 0);
      chk("t5_wr", uart_tx_wr, 0);
      uart_tx_done = 1'b1; tick(); uart_tx_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t5_stray_done", uart_tx_wr, 0);
         tick();
      end

      // Randomized traffic on all inputs.
      for (int i = 0; i < 800; i++) begin
         tx_in_valid  = 1'($urandom_range(0, 1));
         tx_in_data   = 8'($urandom);
         uart_tx_done = ($urandom_range(0, 3) == 0);
         uart_rx_done = ($urandom_range(0, 2) == 0);
         uart_rx_data = 8'($urandom);
         rx_out_ready = ($urandom_range(0, 2) != 0);
         overrun_clr  = ($urandom_range(0, 15) == 0);
         tick();
      end
      overrun_clr = 1'b0;
      drain_tx();
      drain_rx();
      chk("end_tx_scoreboard", tx_exp.size(), 0);
      chk("end_rx_scoreboard", rx_exp.size(), 0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
